// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state set, opcode/funct
// constants and datapath mux encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, RWB, BEQ, JUMP, JAL, JR, FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_SEXT    = 2'b10;
    localparam logic [1:0] ALUB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] REGDST_RT    = 2'b00;
    localparam logic [1:0] REGDST_RD    = 2'b01;
    localparam logic [1:0] REGDST_R31   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT   = 2'b00;
    localparam logic [1:0] M2R_MDR      = 2'b01;
    localparam logic [1:0] M2R_PC       = 2'b10;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_mem_timer.sv
// Memory-wait watchdog: counts consecutive stalled cycles and flags the last
// tolerated one so the controller can move to FAULT on that edge.
module mips_mem_timer #(
    parameter int MEM_TO_W   = 8,
    parameter int MEM_TO_MAX = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clr,
    output logic expired
);

    localparam logic [MEM_TO_W-1:0] LAST = MEM_TO_W'(MEM_TO_MAX - 1);

    logic [MEM_TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr || !stall)
            count <= '0;
        else
            count <= count + MEM_TO_W'(1);
    end

    assign expired = stall && (count == LAST);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with memory-wait watchdog and retired counter.
// Build option MIPS_MC_JAL_EN enables the jal instruction (otherwise illegal).
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TO_W   = 8,
    parameter int MEM_TO_MAX = 200,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t state, state_fsm, state_nx;
    logic   stall, expired, retire;
    logic   unused_zero;

    // The branch decision is taken in the datapath via pc_write_cond.
    assign unused_zero = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (retire)
            retired <= retired + CNT_W'(1);
    end

    assign stall    = mem_req && !mem_ready;
    assign state_nx = expired ? FAULT : state_fsm;

    mips_mem_timer #(
        .MEM_TO_W   (MEM_TO_W),
        .MEM_TO_MAX (MEM_TO_MAX)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .clr     (state_nx != state),
        .expired (expired)
    );

    always_comb begin
        state_fsm     = state;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_B;
        alu_op        = ALUOP_ADD;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        fault         = 1'b0;

        case (state)
            IDLE: state_fsm = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_fsm = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = ALUB_SEXT_SH;
                if (is_mem_op(opcode))
                    state_fsm = MEMADR;
                else if (opcode == OP_RTYPE)
                    state_fsm = (funct == FN_JR) ? JR : EXEC;
                else if (opcode == OP_BEQ)
                    state_fsm = BEQ;
                else if (opcode == OP_J)
                    state_fsm = JUMP;
`ifdef MIPS_MC_JAL_EN
                else if (opcode == OP_JAL)
                    state_fsm = JAL;
`endif
                else begin
                    illegal   = 1'b1;
                    state_fsm = FETCH;
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_SEXT;
                state_fsm = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)
                    state_fsm = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = M2R_MDR;
                retire     = 1'b1;
                state_fsm  = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_fsm = FETCH;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_B;
                alu_op    = ALUOP_FUNCT;
                state_fsm = RWB;
            end
            RWB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = M2R_ALUOUT;
                retire     = 1'b1;
                state_fsm  = FETCH;
            end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALUB_B;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_fsm     = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_src    = PCSRC_JUMP;
                retire    = 1'b1;
                state_fsm = FETCH;
            end
            JAL: begin
`ifdef MIPS_MC_JAL_EN
                reg_write  = 1'b1;
                reg_dst    = REGDST_R31;
                mem_to_reg = M2R_PC;
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                retire     = 1'b1;
`endif
                state_fsm  = FETCH;
            end
            JR: begin
                pc_write  = 1'b1;
                pc_src    = PCSRC_RS;
                retire    = 1'b1;
                state_fsm = FETCH;
            end
            FAULT: fault = 1'b1;
            default: state_fsm = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized self-checking bench for mips_mc_ctrl against an instruction-level
// model of the expected control word sequence and retired count.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic        alu_src_a, reg_write, illegal, fault;
    logic [31:0] retired;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op, reg_dst, mem_to_reg;
        logic       reg_write, illegal, fault;
    } ctl_t;

    typedef enum {
        PH_IDLE, PH_FETCH_WAIT, PH_FETCH_GO, PH_DECODE, PH_DECODE_ILL, PH_MEMADR,
        PH_MEMRD, PH_MEMWB, PH_MEMWR, PH_EXEC, PH_RWB, PH_BEQ, PH_JUMP, PH_JAL,
        PH_JR, PH_FAULT
    } phase_t;

    ctl_t got;
    int   n_chk = 0;
    int   n_fail = 0;
    int   model_ret = 0;

    assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                  reg_write, illegal, fault};

    mips_mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ctl_t expect_ctl(input phase_t p);
        ctl_t c = '0;
        case (p)
            PH_FETCH_WAIT: begin c.mem_req = 1; c.alu_src_b = 2'b01; end
            PH_FETCH_GO: begin
                c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1;
            end
            PH_DECODE:     c.alu_src_b = 2'b11;
            PH_DECODE_ILL: begin c.alu_src_b = 2'b11; c.illegal = 1; end
            PH_MEMADR:     begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            PH_MEMRD:      begin c.mem_req = 1; c.iord = 1; end
            PH_MEMWB:      begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
            PH_MEMWR:      begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; end
            PH_EXEC:       begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            PH_RWB:        begin c.reg_write = 1; c.reg_dst = 2'b01; end
            PH_BEQ: begin
                c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_src = 2'b01;
            end
            PH_JUMP:       begin c.pc_write = 1; c.pc_src = 2'b10; end
            PH_JR:         begin c.pc_write = 1; c.pc_src = 2'b11; end
            PH_JAL: begin
                c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
                c.pc_write = 1; c.pc_src = 2'b10;
            end
            PH_FAULT:      c.fault = 1;
            default:       c = '0;
        endcase
        return c;
    endfunction

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input phase_t p, input logic rdy, input bit ret);
        mem_ready = rdy;
        #3;
        check($sformatf("ctl/%s", p.name()), 64'(got), 64'(expect_ctl(p)));
        check($sformatf("retired/%s", p.name()), 64'(retired), 64'(model_ret));
        @(posedge clk);
        #1;
        if (ret) model_ret++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ctl", 64'(got), 64'(0));
        check("rst_retired", 64'(retired), 64'(0));
        model_ret = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ctl", 64'(got), 64'(expect_ctl(PH_IDLE)));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw);
        bit jal_ok;
`ifdef MIPS_MC_JAL_EN
        jal_ok = 1;
`else
        jal_ok = 0;
`endif
        opcode = op;
        funct  = fn;
        zero   = (op == 6'b000100) ? 1'b1 : rnd_bit();
        repeat (fw) step(PH_FETCH_WAIT, 1'b0, 0);
        step(PH_FETCH_GO, 1'b1, 0);
        if (op == 6'b100011) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_MEMADR, rnd_bit(), 0);
            repeat (mw) step(PH_MEMRD, 1'b0, 0);
            step(PH_MEMRD, 1'b1, 0);
            step(PH_MEMWB, rnd_bit(), 1);
        end else if (op == 6'b101011) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_MEMADR, rnd_bit(), 0);
            repeat (mw) step(PH_MEMWR, 1'b0, 0);
            step(PH_MEMWR, 1'b1, 1);
        end else if (op == 6'b000000 && fn == 6'b001000) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_JR, rnd_bit(), 1);
        end else if (op == 6'b000000) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_EXEC, rnd_bit(), 0);
            step(PH_RWB, rnd_bit(), 1);
        end else if (op == 6'b000100) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_BEQ, rnd_bit(), 1);
        end else if (op == 6'b000010) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_JUMP, rnd_bit(), 1);
        end else if (op == 6'b000011 && jal_ok) begin
            step(PH_DECODE, rnd_bit(), 0);
            step(PH_JAL, rnd_bit(), 1);
        end else begin
            step(PH_DECODE_ILL, rnd_bit(), 0);
        end
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                6'b000010, 6'b000011, 6'b111111, 6'b010101};
        #1;
        do_reset();

        do_instr(6'b000000, 6'b100000, 0, 0);
        check("add_retired", 64'(retired), 64'(1));
        do_instr(6'b100011, 6'b000000, 0, 3);
        do_instr(6'b000100, 6'b000000, 1, 0);
        do_instr(6'b111111, 6'b000000, 0, 0);
        check("illegal_retired", 64'(retired), 64'(model_ret));
        do_instr(6'b101011, 6'b000000, 2, 2);
        do_instr(6'b000010, 6'b000000, 0, 0);
        do_instr(6'b000000, 6'b001000, 0, 0);
        do_instr(6'b000011, 6'b000000, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            do_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 5));
        end

        // Reset arriving while a store is waiting on memory.
        opcode = 6'b101011;
        step(PH_FETCH_GO, 1'b1, 0);
        step(PH_DECODE, 1'b0, 0);
        step(PH_MEMADR, 1'b0, 0);
        mem_ready = 1'b0;
        #3;
        check("memwr_before_rst", 64'(got), 64'(expect_ctl(PH_MEMWR)));
        #1;
        do_reset();
        do_instr(6'b000000, 6'b100101, 0, 0);

        // Stuck fetch: watchdog tolerates 200 stalled cycles, then faults.
        do_reset();
        opcode = 6'($urandom);
        repeat (200) step(PH_FETCH_WAIT, 1'b0, 0);
        repeat (6) step(PH_FAULT, rnd_bit(), 0);
        check("fault_sticky", 64'(fault), 64'(1));
        rst_n = 1'b0;
        #1;
        check("fault_cleared", 64'(fault), 64'(0));
        do_reset();
        do_instr(6'b000010, 6'b000000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
